// File: rtl/seed_a_pkg.sv
// Shared definitions for the seed-A storage protocol.
// Holds the default beat geometry, the storage command encodings and the
// client FSM state encoding. The storage-side bench reuses the state type.
// Contents:
//   SEED_WORD_W, SEED_WORDS, SEED_W   default beat width, beat count, seed width
//   SEEDA_CMD_START_IN/OUT            st_cmd encodings
//   seed_a_state_e                    client FSM states
//   cnt_width()                       beat counter width, never below 1 bit
package seed_a_pkg;

  localparam int unsigned SEED_WORD_W = 64;
  localparam int unsigned SEED_WORDS  = 2;
  localparam int unsigned SEED_W      = SEED_WORD_W * SEED_WORDS;

  localparam logic SEEDA_CMD_START_IN  = 1'b1;
  localparam logic SEEDA_CMD_START_OUT = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StXfer,
    StVcmd,
    StVxfer,
    StRsp
  } seed_a_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seed_a_client_beats.sv
// Beat register file and framing checker for seed_a_client.
// Holds Words x WordW beats, a beat counter, and a sticky error flag.
// Build option: SEED_A_CLIENT_READBACK_VERIFY_EN adds a beat comparator.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   load            latch load_seed, clear counter and error
//   load_seed       whole seed, beat k at [k*WordW +: WordW]
//   step            a beat handshake completes this cycle
//   step_last       isLast flag accompanying that beat
//   wr_en           on step, overwrite the current beat with wr_beat
//   wr_beat         incoming beat
//   cmp_en          (verify build) on step, flag wr_beat != current beat
//   rd_beat         beat at the current counter
//   at_last         counter points at the final beat
//   seed            whole register file
//   err             sticky framing/compare error
module seed_a_client_beats
  import seed_a_pkg::*;
#(
  parameter int unsigned WordW = SEED_WORD_W,
  parameter int unsigned Words = SEED_WORDS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [WordW*Words-1:0] load_seed,
  input  logic                   step,
  input  logic                   step_last,
  input  logic                   wr_en,
  input  logic [WordW-1:0]       wr_beat,
`ifdef SEED_A_CLIENT_READBACK_VERIFY_EN
  input  logic                   cmp_en,
`endif
  output logic [WordW-1:0]       rd_beat,
  output logic                   at_last,
  output logic [WordW*Words-1:0] seed,
  output logic                   err
);

  localparam int unsigned CntW = cnt_width(Words);
  localparam logic [CntW-1:0] LastIdx = CntW'(Words - 1);

  logic [Words-1:0][WordW-1:0] beats_q, beats_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic                        err_q, err_d;
  logic                        beat_bad;

  assign at_last = (cnt_q == LastIdx);
  assign rd_beat = beats_q[cnt_q];
  assign seed    = beats_q;
  assign err     = err_q;

  always_comb begin
    beat_bad = (step_last != at_last);
`ifdef SEED_A_CLIENT_READBACK_VERIFY_EN
    // Compare before the readback beat overwrites the written one.
    if (cmp_en && (wr_beat != rd_beat)) begin
      beat_bad = 1'b1;
    end
`endif
  end

  always_comb begin
    beats_d = beats_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (load) begin
      beats_d = load_seed;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (step) begin
      if (wr_en) begin
        beats_d[cnt_q] = wr_beat;
      end
      // Returning to 0 after the last beat readies the readback pass.
      cnt_d = at_last ? '0 : cnt_q + CntW'(1);
      if (beat_bad) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beats_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/seed_a_client.sv
// Initiator side of the seed-A storage protocol.
// Takes a whole-seed write or read request, issues a start-in/start-out
// command, streams Words beats low word first, checks isLast framing and
// returns one response per request. All outputs decode registered state.
// Build option: SEED_A_CLIENT_READBACK_VERIFY_EN reads the seed back after
// each write and flags any beat that differs.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   req_*                         user request (direction, seed, handshake)
//   rsp_*                         response (seed, err, handshake)
//   st_cmd*                       storage command channel
//   st_in*                        beats toward storage, isLast from storage
//   st_out*                       beats from storage
module seed_a_client
  import seed_a_pkg::*;
#(
  parameter int unsigned WordW = SEED_WORD_W,
  parameter int unsigned Words = SEED_WORDS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_writeElseRead,
  input  logic [WordW*Words-1:0] req_seed,
  input  logic                   req_isReady,
  output logic                   req_canReceive,
  output logic [WordW*Words-1:0] rsp_seed,
  output logic                   rsp_err,
  output logic                   rsp_isReady,
  input  logic                   rsp_canReceive,
  output logic                   st_cmd,
  output logic                   st_cmd_isReady,
  input  logic                   st_cmd_canReceive,
  output logic [WordW-1:0]       st_in,
  output logic                   st_in_isReady,
  input  logic                   st_in_canReceive,
  input  logic                   st_in_isLast,
  input  logic [WordW-1:0]       st_out,
  input  logic                   st_out_isReady,
  output logic                   st_out_canReceive,
  input  logic                   st_out_isLast
);

  seed_a_state_e state_q, state_d;
  logic          dir_q, dir_d;  // 1 = write

  logic             load, step, step_last, wr_en;
  logic [WordW-1:0] rd_beat;
  logic             at_last;
`ifdef SEED_A_CLIENT_READBACK_VERIFY_EN
  logic             cmp_en;
`endif

  seed_a_client_beats #(
    .WordW (WordW),
    .Words (Words)
  ) u_beats (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_seed (req_seed),
    .step      (step),
    .step_last (step_last),
    .wr_en     (wr_en),
    .wr_beat   (st_out),
`ifdef SEED_A_CLIENT_READBACK_VERIFY_EN
    .cmp_en    (cmp_en),
`endif
    .rd_beat   (rd_beat),
    .at_last   (at_last),
    .seed      (rsp_seed),
    .err       (rsp_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    unique case (state_q)
      StIdle: begin
        if (req_isReady) begin
          dir_d   = req_writeElseRead;
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (st_cmd_canReceive) begin
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (dir_q) begin
          if (st_in_canReceive && at_last) begin
`ifdef SEED_A_CLIENT_READBACK_VERIFY_EN
            state_d = StVcmd;
`else
            state_d = StRsp;
`endif
          end
        end else if (st_out_isReady && at_last) begin
          state_d = StRsp;
        end
      end
`ifdef SEED_A_CLIENT_READBACK_VERIFY_EN
      StVcmd: begin
        if (st_cmd_canReceive) begin
          state_d = StVxfer;
        end
      end
      StVxfer: begin
        if (st_out_isReady && at_last) begin
          state_d = StRsp;
        end
      end
`endif
      StRsp: begin
        if (rsp_canReceive) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_canReceive    = (state_q == StIdle);
    st_cmd_isReady    = 1'b0;
    st_cmd            = SEEDA_CMD_START_OUT;
    st_in             = rd_beat;
    st_in_isReady     = 1'b0;
    st_out_canReceive = 1'b0;
    rsp_isReady       = 1'b0;
    load              = 1'b0;
    step              = 1'b0;
    step_last         = 1'b0;
    wr_en             = 1'b0;
`ifdef SEED_A_CLIENT_READBACK_VERIFY_EN
    cmp_en            = 1'b0;
`endif
    unique case (state_q)
      StIdle: load = req_isReady;
      StCmd: begin
        st_cmd_isReady = 1'b1;
        st_cmd         = dir_q ? SEEDA_CMD_START_IN : SEEDA_CMD_START_OUT;
      end
      StXfer: begin
        if (dir_q) begin
          st_in_isReady = 1'b1;
          step          = st_in_canReceive;
          step_last     = st_in_isLast;
        end else begin
          st_out_canReceive = 1'b1;
          step              = st_out_isReady;
          step_last         = st_out_isLast;
          wr_en             = 1'b1;
        end
      end
`ifdef SEED_A_CLIENT_READBACK_VERIFY_EN
      StVcmd: begin
        st_cmd_isReady = 1'b1;
        st_cmd         = SEEDA_CMD_START_OUT;
      end
      StVxfer: begin
        st_out_canReceive = 1'b1;
        step              = st_out_isReady;
        step_last         = st_out_isLast;
        wr_en             = 1'b1;
        cmp_en            = 1'b1;
      end
`endif
      StRsp: rsp_isReady = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seed_a_client.sv
// Bench for seed_a_client: a storage model plus a transaction-level
// reference. Every negedge the compare process drives the storage and
// response-side inputs, then checks outputs and handshakes against the model.
module tb_seed_a_client;
  import seed_a_pkg::*;

  localparam int unsigned WordW = SEED_WORD_W;
  localparam int unsigned Words = SEED_WORDS;
  localparam int unsigned SeedW = SEED_W;
  localparam logic [Words-1:0] LastOk = Words'(1) << (Words - 1);
  localparam int unsigned TxnBound = 400;

  typedef logic [SeedW-1:0] cmp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_writeElseRead = 1'b0;
  logic [SeedW-1:0] req_seed = '0;
  logic             req_isReady = 1'b0;
  logic             req_canReceive;
  logic [SeedW-1:0] rsp_seed;
  logic             rsp_err, rsp_isReady;
  logic             rsp_canReceive = 1'b0;
  logic             st_cmd, st_cmd_isReady;
  logic             st_cmd_canReceive = 1'b0;
  logic [WordW-1:0] st_in;
  logic             st_in_isReady;
  logic             st_in_canReceive = 1'b0;
  logic             st_in_isLast = 1'b0;
  logic [WordW-1:0] st_out = '0;
  logic             st_out_isReady = 1'b0;
  logic             st_out_canReceive;
  logic             st_out_isLast = 1'b0;

  always #5 clk = ~clk;

  seed_a_client dut (
    .clk               (clk),
    .rst               (rst),
    .req_writeElseRead (req_writeElseRead),
    .req_seed          (req_seed),
    .req_isReady       (req_isReady),
    .req_canReceive    (req_canReceive),
    .rsp_seed          (rsp_seed),
    .rsp_err           (rsp_err),
    .rsp_isReady       (rsp_isReady),
    .rsp_canReceive    (rsp_canReceive),
    .st_cmd            (st_cmd),
    .st_cmd_isReady    (st_cmd_isReady),
    .st_cmd_canReceive (st_cmd_canReceive),
    .st_in             (st_in),
    .st_in_isReady     (st_in_isReady),
    .st_in_canReceive  (st_in_canReceive),
    .st_in_isLast      (st_in_isLast),
    .st_out            (st_out),
    .st_out_isReady    (st_out_isReady),
    .st_out_canReceive (st_out_canReceive),
    .st_out_isLast     (st_out_isLast)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;

  // Outstanding request model
  bit               busy = 1'b0, done = 1'b0, cur_wr = 1'b0, cur_stall = 1'b0;
  logic [SeedW-1:0] exp_rsp_seed = '0;
  bit               exp_err = 1'b0;
  int unsigned      exp_lat = 0, req_cyc = 0;
  logic [WordW-1:0] exp_in [Words];
  bit               exp_cmd_q [$];
  logic [Words-1:0] cur_wlast = '0, cur_rlast = '0;
  logic [WordW-1:0] cur_rdata [Words];
  logic [WordW-1:0] cur_corrupt [Words];

  // Storage model
  int unsigned      st_in_idx = Words, st_out_idx = 0, st_out_left = 0;
  logic [WordW-1:0] stored [Words];
  logic [WordW-1:0] out_beats [Words];
  logic [Words-1:0] out_last = '0;

  // Captured results of the last completed request
  logic [WordW-1:0] cap_in [Words];
  logic [SeedW-1:0] cap_rsp_seed = '0;
  logic             cap_rsp_err = 1'b0;
  int unsigned      cap_lat = 0;

  task automatic check(input string name, input cmp_t act, input cmp_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got no/extra event, expected protocol event", name);
  endtask

  function automatic bit rnd_ready();
    return cur_stall ? ($urandom_range(0, 2) == 0) : 1'b1;
  endfunction

  task automatic model_reset();
    busy = 1'b0;
    done = 1'b0;
    exp_cmd_q.delete();
    st_in_idx   = Words;
    st_out_idx  = 0;
    st_out_left = 0;
  endtask

  // Compare process: outputs are stable from the negedge to the next posedge,
  // so handshakes decided here are the ones the coming edge will commit.
  initial begin : compare_proc
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        check("req_canReceive", cmp_t'(req_canReceive), cmp_t'(!busy));
        if (!busy) begin
          check("idle_quiet", cmp_t'({st_cmd_isReady, st_in_isReady, st_out_canReceive,
                                      rsp_isReady}), '0);
        end

        st_cmd_canReceive = rnd_ready();
        st_in_canReceive  = rnd_ready();
        st_in_isLast      = (st_in_idx < Words) ? cur_wlast[st_in_idx] : 1'b0;
        st_out_isReady    = (st_out_left != 0) && rnd_ready();
        st_out            = (st_out_idx < Words) ? out_beats[st_out_idx] : '0;
        st_out_isLast     = (st_out_idx < Words) ? out_last[st_out_idx] : 1'b0;
        rsp_canReceive    = rnd_ready();

        if (req_isReady && req_canReceive) begin
          busy    = 1'b1;
          done    = 1'b0;
          req_cyc = cyc;
        end
        if (st_cmd_isReady && st_cmd_canReceive) begin
          if (exp_cmd_q.size() == 0) fail_now("st_cmd_unexpected");
          else check("st_cmd", cmp_t'(st_cmd), cmp_t'(exp_cmd_q.pop_front()));
          if (st_cmd == SEEDA_CMD_START_OUT) begin
            for (int k = 0; k < Words; k++) begin
              out_beats[k] = cur_wr ? (stored[k] ^ cur_corrupt[k]) : cur_rdata[k];
            end
            out_last    = cur_wr ? LastOk : cur_rlast;
            st_out_idx  = 0;
            st_out_left = Words;
          end else begin
            st_in_idx = 0;
          end
        end
        if (st_in_isReady && st_in_canReceive) begin
          if (st_in_idx >= Words) fail_now("st_in_extra_beat");
          else begin
            check("st_in_beat", cmp_t'(st_in), cmp_t'(exp_in[st_in_idx]));
            stored[st_in_idx] = st_in;
            cap_in[st_in_idx] = st_in;
            st_in_idx++;
          end
        end
        if (st_out_isReady && st_out_canReceive) begin
          st_out_idx++;
          st_out_left--;
        end
        if (rsp_isReady && rsp_canReceive) begin
          if (!busy) fail_now("rsp_unexpected");
          else begin
            check("rsp_seed", rsp_seed, exp_rsp_seed);
            check("rsp_err", cmp_t'(rsp_err), cmp_t'(exp_err));
            check("beat_count", cmp_t'(cur_wr ? st_in_idx : st_out_idx), cmp_t'(Words));
            check("cmds_left", cmp_t'(exp_cmd_q.size()), '0);
            if (!cur_stall) check("latency", cmp_t'(cyc - req_cyc), cmp_t'(exp_lat));
            cap_rsp_seed = rsp_seed;
            cap_rsp_err  = rsp_err;
            cap_lat      = cyc - req_cyc;
            busy = 1'b0;
            done = 1'b1;
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic start_txn(input bit wr, input logic [SeedW-1:0] seed,
                           input logic [Words-1:0] wlast, input logic [SeedW-1:0] rdata,
                           input logic [Words-1:0] rlast, input logic [SeedW-1:0] corrupt,
                           input bit stall);
    @(posedge clk);
    #1;
    cur_wr    = wr;
    cur_stall = stall;
    cur_wlast = wlast;
    cur_rlast = rlast;
    for (int k = 0; k < Words; k++) begin
      exp_in[k]      = seed[k*WordW +: WordW];
      cur_rdata[k]   = rdata[k*WordW +: WordW];
      cur_corrupt[k] = corrupt[k*WordW +: WordW];
    end
    exp_cmd_q.delete();
    if (wr) begin
      exp_cmd_q.push_back(SEEDA_CMD_START_IN);
      exp_rsp_seed = seed;
      exp_err      = (wlast != LastOk);
      exp_lat      = 2 + Words;
`ifdef SEED_A_CLIENT_READBACK_VERIFY_EN
      exp_cmd_q.push_back(SEEDA_CMD_START_OUT);
      exp_rsp_seed = seed ^ corrupt;
      exp_err      = exp_err || (corrupt != '0);
      exp_lat      = exp_lat + 1 + Words;
`endif
    end else begin
      exp_cmd_q.push_back(SEEDA_CMD_START_OUT);
      exp_rsp_seed = rdata;
      exp_err      = (rlast != LastOk);
      exp_lat      = 2 + Words;
    end
    done              = 1'b0;
    req_writeElseRead = wr;
    req_seed          = seed;
    req_isReady       = 1'b1;
    for (int i = 0; i < TxnBound && !busy; i++) begin
      @(posedge clk);
      #1;
    end
    req_isReady = 1'b0;
    if (!busy) fail_now("req_accept_timeout");
  endtask

  task automatic wait_done();
    for (int i = 0; i < TxnBound && !done; i++) begin
      @(posedge clk);
      #1;
    end
    if (!done) begin
      fail_now("rsp_timeout");
      do_reset();
    end
  endtask

  task automatic run_txn(input bit wr, input logic [SeedW-1:0] seed,
                         input logic [Words-1:0] wlast, input logic [SeedW-1:0] rdata,
                         input logic [Words-1:0] rlast, input logic [SeedW-1:0] corrupt,
                         input bit stall);
    start_txn(wr, seed, wlast, rdata, rlast, corrupt, stall);
    wait_done();
  endtask

  initial begin : main_proc
    logic [SeedW-1:0] s, d, c;
    logic [Words-1:0] wl, rl;

    // Reset state
    #1;
    check("reset_valids", cmp_t'({st_cmd_isReady, st_in_isReady, st_out_canReceive,
                                  rsp_isReady}), '0);
    check("reset_rsp_seed", rsp_seed, '0);
    check("reset_rsp_err", cmp_t'(rsp_err), '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_canReceive", cmp_t'(req_canReceive), cmp_t'(1));
    rst = 1'b1;

    // Directed write, no stalls
    run_txn(1'b1, 128'h0123456789ABCDEF_FEDCBA9876543210, LastOk, '0, LastOk, '0, 1'b0);
    check("wr_beat0_lit", cmp_t'(cap_in[0]), cmp_t'(64'hFEDCBA9876543210));
    check("wr_beat1_lit", cmp_t'(cap_in[1]), cmp_t'(64'h0123456789ABCDEF));
    check("wr_err_lit", cmp_t'(cap_rsp_err), '0);
`ifdef SEED_A_CLIENT_READBACK_VERIFY_EN
    check("wr_lat_lit", cmp_t'(cap_lat), cmp_t'(7));
`else
    check("wr_lat_lit", cmp_t'(cap_lat), cmp_t'(4));
    check("wr_echo_lit", cap_rsp_seed, 128'h0123456789ABCDEF_FEDCBA9876543210);
`endif

    // Directed read, no stalls
    run_txn(1'b0, '0, LastOk, 128'h2222222222222222_1111111111111111, LastOk, '0, 1'b0);
    check("rd_seed_lit", cap_rsp_seed, 128'h2222222222222222_1111111111111111);
    check("rd_err_lit", cmp_t'(cap_rsp_err), '0);
    check("rd_lat_lit", cmp_t'(cap_lat), cmp_t'(4));

    // Framing errors
    run_txn(1'b1, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 2'b11, '0, LastOk, '0, 1'b0);
    check("early_last_err_lit", cmp_t'(cap_rsp_err), cmp_t'(1));
    check("early_last_beats_lit", cmp_t'(st_in_idx), cmp_t'(2));
    run_txn(1'b0, '0, LastOk, 128'h0BAD_0000_0000_0001_0BAD_0000_0000_0002, 2'b00, '0, 1'b1);
    check("missing_last_err_lit", cmp_t'(cap_rsp_err), cmp_t'(1));

    // Reset during beat 1 of a write, then a clean read
    start_txn(1'b1, 128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0002, LastOk, '0, LastOk, '0,
              1'b0);
    for (int i = 0; i < TxnBound && st_in_idx != 1; i++) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_beat1_valid", cmp_t'(st_in_isReady), cmp_t'(1));
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_valids", cmp_t'({st_cmd_isReady, st_in_isReady, st_out_canReceive,
                                rsp_isReady}), '0);
    check("rst_rsp", cmp_t'({rsp_err, rsp_seed}), '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_idle", cmp_t'(req_canReceive), cmp_t'(1));
    run_txn(1'b0, '0, LastOk, 128'h3333333333333333_4444444444444444, LastOk, '0, 1'b0);
    check("post_rst_read_lit", cap_rsp_seed, 128'h3333333333333333_4444444444444444);

`ifdef SEED_A_CLIENT_READBACK_VERIFY_EN
    // Readback corrupted at bit 5 of beat 0
    run_txn(1'b1, 128'h0123456789ABCDEF_FEDCBA9876543210, LastOk, '0, LastOk, 128'h20, 1'b0);
    check("vfy_err_lit", cmp_t'(cap_rsp_err), cmp_t'(1));
    check("vfy_seed_lit", cap_rsp_seed, 128'h0123456789ABCDEF_FEDCBA9876543230);
`endif

    // Randomized traffic with stalls
    for (int t = 0; t < 40; t++) begin
      s  = {$urandom(), $urandom(), $urandom(), $urandom()};
      d  = {$urandom(), $urandom(), $urandom(), $urandom()};
      wl = ($urandom_range(0, 3) == 0) ? Words'($urandom()) : LastOk;
      rl = ($urandom_range(0, 3) == 0) ? Words'($urandom()) : LastOk;
      c  = '0;
`ifdef SEED_A_CLIENT_READBACK_VERIFY_EN
      if ($urandom_range(0, 2) == 0) c[$urandom_range(0, SeedW - 1)] = 1'b1;
`endif
      run_txn(1'($urandom_range(0, 1)), s, wl, d, rl, c, 1'($urandom_range(0, 3) != 0));
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
